// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// Holds the FSM state encoding, default sizes and the one-hot helper.
package reg_write_arbiter_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  function automatic logic [MAX_REQ-1:0] onehot(
    input logic [2:0] idx
  );
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Round-robin winner search starting at ptr, wrapping modulo N_REQ.
// Purely combinational; the first requesting index at or after ptr wins.
module rr_picker
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             any_req
);

  int            sum;
  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest one wins last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = IW'(sum);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter driving one enable-gated register.
// Four-phase req/ack; exactly one registered regEn pulse per grant.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wrData,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic                   regEn,
  output logic [WIDTH-1:0]       regData,
  output logic                   busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               regen_q, regen_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               busy_q, busy_d;
  logic [IW-1:0]      pick;
  logic               any_req;
  logic [MAX_REQ-1:0] oh_pick;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (pick),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   state_d = ACK;
      ACK:     state_d = RELEASE;
      RELEASE: if (!req[win_q]) state_d = IDLE;
    endcase
  end

  // Output bundle is computed one cycle ahead so every port is a flop.
  always_comb begin
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    ack_d   = '0;
    regen_d = 1'b0;
    data_d  = data_q;
    busy_d  = busy_q;
    oh_pick = onehot(3'(pick));
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d   = pick;
          grant_d = oh_pick[N_REQ-1:0];
          regen_d = 1'b1;
          data_d  = wrData[pick*WIDTH +: WIDTH];
          busy_d  = 1'b1;
        end
      end
      GRANT:   ack_d = grant_q;
      ACK: begin
        if (win_q == IW'(N_REQ - 1)) ptr_d = '0;
        else                         ptr_d = win_q + 1'b1;
      end
      RELEASE: begin
        if (!req[win_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      regen_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      regen_q <= regen_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign grant   = grant_q;
  assign ack     = ack_q;
  assign regEn   = regen_q;
  assign regData = data_q;
  assign busy    = busy_q;

endmodule
